// File: rtl/mul_pipe_ctrl.sv
// Three-stage issue pipeline around the combinational multiplier: operand register,
// product register, output register, with rename/speculation tags and branch squash.
module mul_pipe_ctrl #(
  parameter int DATA_LEN    = 32,
  parameter int RRF_SEL     = 6,
  parameter int SPECTAG_LEN = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [DATA_LEN-1:0]    req_src1,
  input  logic [DATA_LEN-1:0]    req_src2,
  input  logic                   req_src1_signed,
  input  logic                   req_src2_signed,
  input  logic                   req_sel_lohi,
  input  logic [RRF_SEL-1:0]     req_rrftag,
  input  logic [SPECTAG_LEN-1:0] req_spectag,
  input  logic                   prmiss,
  input  logic [SPECTAG_LEN-1:0] prmiss_mask,
  input  logic                   prsuccess,
  input  logic [SPECTAG_LEN-1:0] prsuccess_mask,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DATA_LEN-1:0]    res_data,
  output logic [RRF_SEL-1:0]     res_rrftag,
  output logic [SPECTAG_LEN-1:0] res_spectag,
  output logic [1:0]             inflight
);

  logic                   s0_v_q, s0_v_d, s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [DATA_LEN-1:0]    s0_src1_q, s0_src1_d, s0_src2_q, s0_src2_d;
  logic                   s0_sg1_q, s0_sg1_d, s0_sg2_q, s0_sg2_d, s0_hi_q, s0_hi_d;
  logic [RRF_SEL-1:0]     s0_tag_q, s0_tag_d, s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
  logic [SPECTAG_LEN-1:0] s0_spec_q, s0_spec_d, s1_spec_q, s1_spec_d, s2_spec_q, s2_spec_d;
  logic [DATA_LEN-1:0]    s1_data_q, s1_data_d, s2_data_q, s2_data_d;

  logic                   adv0, adv1, adv2, fire;
  logic [SPECTAG_LEN-1:0] kill_mask, clr_mask;
  logic [2*DATA_LEN-1:0]  op1, op2, prod;
  logic [DATA_LEN-1:0]    prod_word;

  assign adv2      = !s2_v_q || res_ready;
  assign adv1      = !s1_v_q || adv2;
  assign adv0      = !s0_v_q || adv1;
  assign req_ready = adv0 && !reset;
  assign fire      = req_valid && req_ready;

  // prmiss takes priority: a simultaneous prsuccess clears nothing.
  assign kill_mask = prmiss ? prmiss_mask : '0;
  assign clr_mask  = (prsuccess && !prmiss) ? prsuccess_mask : '0;

  // Extending both operands to the full product width makes the modular product
  // exactly the low 2*DATA_LEN bits of the true signed/unsigned product.
  assign op1       = {{DATA_LEN{s0_sg1_q & s0_src1_q[DATA_LEN-1]}}, s0_src1_q};
  assign op2       = {{DATA_LEN{s0_sg2_q & s0_src2_q[DATA_LEN-1]}}, s0_src2_q};
  assign prod      = op1 * op2;
  assign prod_word = s0_hi_q ? prod[2*DATA_LEN-1:DATA_LEN] : prod[DATA_LEN-1:0];

  always_comb begin
    s0_src1_d = s0_src1_q;
    s0_src2_d = s0_src2_q;
    s0_sg1_d  = s0_sg1_q;
    s0_sg2_d  = s0_sg2_q;
    s0_hi_d   = s0_hi_q;
    s0_tag_d  = s0_tag_q;
    s1_data_d = s1_data_q;
    s1_tag_d  = s1_tag_q;
    s2_data_d = s2_data_q;
    s2_tag_d  = s2_tag_q;
    s0_spec_d = s0_spec_q & ~clr_mask;
    s1_spec_d = s1_spec_q & ~clr_mask;
    s2_spec_d = s2_spec_q & ~clr_mask;
    s0_v_d    = s0_v_q && ((s0_spec_q & kill_mask) == '0);
    s1_v_d    = s1_v_q && ((s1_spec_q & kill_mask) == '0);
    s2_v_d    = s2_v_q && ((s2_spec_q & kill_mask) == '0);

    if (adv2) begin
      s2_v_d = s1_v_q && ((s1_spec_q & kill_mask) == '0);
      if (s1_v_q) begin
        s2_data_d = s1_data_q;
        s2_tag_d  = s1_tag_q;
        s2_spec_d = s1_spec_q & ~clr_mask;
      end
    end

    if (adv1) begin
      s1_v_d = s0_v_q && ((s0_spec_q & kill_mask) == '0);
      if (s0_v_q) begin
        s1_data_d = prod_word;
        s1_tag_d  = s0_tag_q;
        s1_spec_d = s0_spec_q & ~clr_mask;
      end
    end

    // A squashed request still completes its handshake; it just lands invalid.
    if (adv0) begin
      s0_v_d = fire && ((req_spectag & kill_mask) == '0);
      if (fire) begin
        s0_src1_d = req_src1;
        s0_src2_d = req_src2;
        s0_sg1_d  = req_src1_signed;
        s0_sg2_d  = req_src2_signed;
        s0_hi_d   = req_sel_lohi;
        s0_tag_d  = req_rrftag;
        s0_spec_d = req_spectag & ~clr_mask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_v_q    <= 1'b0;
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s0_src1_q <= '0;
      s0_src2_q <= '0;
      s0_sg1_q  <= 1'b0;
      s0_sg2_q  <= 1'b0;
      s0_hi_q   <= 1'b0;
      s0_tag_q  <= '0;
      s0_spec_q <= '0;
      s1_data_q <= '0;
      s1_tag_q  <= '0;
      s1_spec_q <= '0;
      s2_data_q <= '0;
      s2_tag_q  <= '0;
      s2_spec_q <= '0;
    end else begin
      s0_v_q    <= s0_v_d;
      s1_v_q    <= s1_v_d;
      s2_v_q    <= s2_v_d;
      s0_src1_q <= s0_src1_d;
      s0_src2_q <= s0_src2_d;
      s0_sg1_q  <= s0_sg1_d;
      s0_sg2_q  <= s0_sg2_d;
      s0_hi_q   <= s0_hi_d;
      s0_tag_q  <= s0_tag_d;
      s0_spec_q <= s0_spec_d;
      s1_data_q <= s1_data_d;
      s1_tag_q  <= s1_tag_d;
      s1_spec_q <= s1_spec_d;
      s2_data_q <= s2_data_d;
      s2_tag_q  <= s2_tag_d;
      s2_spec_q <= s2_spec_d;
    end
  end

  assign res_valid   = s2_v_q;
  assign res_data    = s2_data_q;
  assign res_rrftag  = s2_tag_q;
  assign res_spectag = s2_spec_q;
  assign inflight    = {1'b0, s0_v_q} + {1'b0, s1_v_q} + {1'b0, s2_v_q};

endmodule

// File: tb/tb_mul_pipe_ctrl.sv
// Bench for mul_pipe_ctrl: an ordered in-flight queue model checked every cycle,
// plus directed scenarios with hand-computed literal results.
module tb_mul_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_src1 = '0, req_src2 = '0;
  logic        req_src1_signed = 1'b0, req_src2_signed = 1'b0, req_sel_lohi = 1'b0;
  logic [5:0]  req_rrftag = '0;
  logic [4:0]  req_spectag = '0;
  logic        prmiss = 1'b0, prsuccess = 1'b0;
  logic [4:0]  prmiss_mask = '0, prsuccess_mask = '0;
  logic        res_ready = 1'b0;
  logic        req_ready, res_valid;
  logic [31:0] res_data;
  logic [5:0]  res_rrftag;
  logic [4:0]  res_spectag;
  logic [1:0]  inflight;

  mul_pipe_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src1(req_src1), .req_src2(req_src2),
    .req_src1_signed(req_src1_signed), .req_src2_signed(req_src2_signed),
    .req_sel_lohi(req_sel_lohi), .req_rrftag(req_rrftag), .req_spectag(req_spectag),
    .prmiss(prmiss), .prmiss_mask(prmiss_mask),
    .prsuccess(prsuccess), .prsuccess_mask(prsuccess_mask),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_rrftag(res_rrftag), .res_spectag(res_spectag), .inflight(inflight)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  tag;
    logic [4:0]  spec;
    int          stage;
  } ent_t;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  tag;
    int          c;
  } out_t;

  ent_t mq[$];        // in-flight ops, oldest first
  out_t olog[$];
  int   acc_cyc[$];
  bit   zero_s2 = 1'b1;
  int   cyc = 0, acc_dut = 0, errors = 0, checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic sa, input logic sb, input logic hi);
    longint x, y;
    logic [63:0] p;
    x = sa ? longint'($signed(a)) : longint'(a);
    y = sb ? longint'($signed(b)) : longint'(b);
    p = 64'(x * y);
    return hi ? p[63:32] : p[31:0];
  endfunction

  // Each op moves one stage forward per edge unless the slot ahead stays occupied.
  task automatic model_edge();
    ent_t e;
    int   blocked, nxt;
    bit   fire;
    cyc++;
    if (reset) begin
      mq.delete();
      zero_s2 = 1'b1;
      return;
    end
    fire = req_valid && !(mq.size() == 3 && !res_ready);
    if (mq.size() > 0 && mq[0].stage == 2 && res_ready) void'(mq.pop_front());
    blocked = 3;
    foreach (mq[i]) begin
      nxt = (mq[i].stage + 1 < blocked) ? mq[i].stage + 1 : mq[i].stage;
      if (nxt == 2 && mq[i].stage != 2) zero_s2 = 1'b0;
      mq[i].stage = nxt;
      blocked = nxt;
    end
    if (fire) begin
      e.data  = ref_mul(req_src1, req_src2, req_src1_signed, req_src2_signed, req_sel_lohi);
      e.tag   = req_rrftag;
      e.spec  = req_spectag;
      e.stage = 0;
      mq.push_back(e);
      acc_cyc.push_back(cyc);
    end
    if (prmiss) begin
      for (int i = mq.size() - 1; i >= 0; i--)
        if ((mq[i].spec & prmiss_mask) != 0) mq.delete(i);
    end else if (prsuccess) begin
      foreach (mq[i]) mq[i].spec = mq[i].spec & ~prsuccess_mask;
    end
  endtask

  task automatic compare();
    bit exp_valid;
    exp_valid = (mq.size() > 0 && mq[0].stage == 2);
    check("req_ready", req_ready, reset ? 1'b0 : !(mq.size() == 3 && !res_ready));
    check("res_valid", res_valid, exp_valid);
    check("inflight", inflight, mq.size());
    if (exp_valid) begin
      check("res_data", res_data, mq[0].data);
      check("res_rrftag", res_rrftag, mq[0].tag);
      check("res_spectag", res_spectag, mq[0].spec);
    end else if (zero_s2) begin
      check("res_data_zero", res_data, 0);
      check("res_rrftag_zero", res_rrftag, 0);
      check("res_spectag_zero", res_spectag, 0);
    end
    if (res_valid && res_ready && !reset) olog.push_back('{res_data, res_rrftag, cyc});
    if (req_valid && req_ready) acc_dut++;
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  initial forever begin
    @(negedge clk);
    compare();
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic sa, input logic sb, input logic hi,
                       input logic [5:0] tag, input logic [4:0] spec);
    req_valid = v;  req_src1 = a;  req_src2 = b;
    req_src1_signed = sa;  req_src2_signed = sb;  req_sel_lohi = hi;
    req_rrftag = tag;  req_spectag = spec;
  endtask

  int base;

  initial begin
    tick(2);
    check("reset_inflight", inflight, 0);
    check("reset_res_valid", res_valid, 0);

    // back-to-back issue
    reset = 1'b0;
    res_ready = 1'b1;
    olog.delete();
    acc_cyc.delete();
    #1;
    check("ready_after_reset", req_ready, 1);
    drive(1, 32'd3, 32'd4, 0, 0, 0, 6'd1, 5'd0);                 tick();
    drive(1, 32'hFFFF_FFFE, 32'd5, 1, 1, 0, 6'd2, 5'd0);         tick();
    drive(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 6'd3, 5'd0); tick();
    drive(1, 32'h8000_0000, 32'd2, 1, 0, 1, 6'd4, 5'd0);         tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick(5);
    check("b2b_count", olog.size(), 4);
    check("b2b_d0", olog[0].data, 32'd12);
    check("b2b_d1", olog[1].data, 32'hFFFF_FFF6);
    check("b2b_d2", olog[2].data, 32'hFFFF_FFFE);
    check("b2b_d3", olog[3].data, 32'hFFFF_FFFF);
    check("b2b_t0", olog[0].tag, 6'd1);
    check("b2b_t3", olog[3].tag, 6'd4);
    check("b2b_latency", olog[0].c - acc_cyc[0], 2);
    check("b2b_throughput", olog[3].c - olog[0].c, 3);

    // backpressure
    olog.delete();
    res_ready = 1'b0;
    base = acc_dut;
    for (int k = 0; k < 5; k++) begin
      drive(1, 32'(k + 2), 32'd3, 0, 0, 0, 6'(10 + k), 5'd0);
      tick();
    end
    check("bp_accepted", acc_dut - base, 3);
    check("bp_ready_low", req_ready, 0);
    check("bp_inflight", inflight, 3);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    res_ready = 1'b1;
    tick(5);
    check("bp_count", olog.size(), 3);
    check("bp_t0", olog[0].tag, 6'd10);
    check("bp_t1", olog[1].tag, 6'd11);
    check("bp_t2", olog[2].tag, 6'd12);
    check("bp_d2", olog[2].data, 32'd12);

    // mispredict squash
    olog.delete();
    res_ready = 1'b0;
    drive(1, 32'd7, 32'd6, 0, 0, 0, 6'd20, 5'b00001); tick();
    drive(1, 32'd7, 32'd7, 0, 0, 0, 6'd21, 5'b00010); tick();
    drive(1, 32'd7, 32'd8, 0, 0, 0, 6'd22, 5'b00010); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    prmiss = 1'b1;
    prmiss_mask = 5'b00010;
    tick();
    prmiss = 1'b0;
    check("miss_inflight", inflight, 1);
    res_ready = 1'b1;
    tick(3);
    check("miss_count", olog.size(), 1);
    check("miss_tag", olog[0].tag, 6'd20);
    check("miss_data", olog[0].data, 32'd42);

    // success clear
    olog.delete();
    res_ready = 1'b0;
    drive(1, 32'd100, 32'd200, 0, 0, 0, 6'd30, 5'b00100); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    prsuccess = 1'b1;
    prsuccess_mask = 5'b00100;
    tick();
    prsuccess = 1'b0;
    tick(2);
    check("succ_valid", res_valid, 1);
    check("succ_spectag", res_spectag, 0);
    prmiss = 1'b1;
    prmiss_mask = 5'b00100;
    tick();
    prmiss = 1'b0;
    check("succ_survives", inflight, 1);
    res_ready = 1'b1;
    tick(2);
    check("succ_count", olog.size(), 1);
    check("succ_data", olog[0].data, 32'd20000);

    // concurrent prmiss/prsuccess with accept
    olog.delete();
    base = acc_dut;
    drive(1, 32'd5, 32'd5, 0, 0, 0, 6'd40, 5'b01000);
    prmiss = 1'b1;  prmiss_mask = 5'b01000;
    prsuccess = 1'b1;  prsuccess_mask = 5'b01000;
    #1;
    check("both_ready", req_ready, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    prmiss = 1'b0;
    prsuccess = 1'b0;
    tick(4);
    check("both_handshake", acc_dut - base, 1);
    check("both_count", olog.size(), 0);
    check("both_inflight", inflight, 0);

    // reset mid-flight
    olog.delete();
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'd9, 32'(k + 1), 0, 0, 0, 6'(50 + k), 5'd0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("pre_rst_inflight", inflight, 3);
    reset = 1'b1;
    tick();
    check("rst_res_valid", res_valid, 0);
    check("rst_inflight", inflight, 0);
    check("rst_res_data", res_data, 0);
    check("rst_ready_low", req_ready, 0);
    reset = 1'b0;
    #1;
    check("rst_ready_high", req_ready, 1);
    res_ready = 1'b1;
    tick(4);
    check("rst_no_output", olog.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_pipe_ctrl.md
# mul_pipe_ctrl

Three-stage pipelined issue controller for the combinational signed/unsigned multiplier datapath in the out-of-order core. It accepts one multiply micro-op per cycle from the MUL reservation station through a valid/ready handshake and registers the operands ahead of the multiplier. It carries the rename tag (RRF index) and speculation tag alongside the data, squashes in-flight ops on branch mispredict, and presents results to the common data bus arbiter with backpressure.

## Interface
- DATA_LEN, 32, operand/result width
- RRF_SEL, 6, rename-register tag width
- SPECTAG_LEN, 5, one-hot speculation tag width

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  micro-op offered
- req_ready  out  1  controller accepts this cycle
- req_src1, req_src2  in  DATA_LEN  operands
- req_src1_signed, req_src2_signed  in  1  operand signedness (MUL/MULH/MULHSU/MULHU decode)
- req_sel_lohi  in  1  0 = low word, 1 = high word of the 2·DATA_LEN product
- req_rrftag  in  RRF_SEL  destination rename tag
- req_spectag  in  SPECTAG_LEN  speculation tag (one-hot, or 0 if non-speculative)
- prmiss  in  1  branch mispredict this cycle
- prmiss_mask  in  SPECTAG_LEN  tags to squash
- prsuccess  in  1  branch resolved correct this cycle
- prsuccess_mask  in  SPECTAG_LEN  tag bits to clear
- res_valid  out  1  result available
- res_ready  in  1  CDB arbiter takes result
- res_data  out  DATA_LEN  selected product word
- res_rrftag  out  RRF_SEL  tag of result
- res_spectag  out  SPECTAG_LEN  current speculation tag of result
- inflight  out  2  number of valid stages (0–3)

## Operation
- Stages: S0 holds operands, controls, and tags. S1 holds the selected product word, computed combinationally from S0 by the multiplier instance, plus tags. S2 is the output register and drives res_*.
- Handshake: transfer when req_valid && req_ready; result consumed when res_valid && res_ready.
- Advance rules, per edge:
  - adv2 = !S2.v || res_ready
  - adv1 = !S1.v || adv2
  - adv0 = !S0.v || adv1
- A stage that advances loads from the previous stage. Bubbles collapse.
- req_ready = adv0 && !reset (combinational).
- Width rules: full 2·DATA_LEN product. Signed operands are sign-extended and unsigned operands zero-extended to DATA_LEN+1 bits. Low word = bits [DATA_LEN-1:0]; high word = bits [2·DATA_LEN-1:DATA_LEN].
- Mispredict: on prmiss, every stage with (spectag & prmiss_mask) ≠ 0 is invalidated at the edge. This includes S2 even if res_ready is high that cycle. An incoming request whose tag matches is accepted (handshake completes) but written invalid. Unmatched stages advance normally.
- Success: on prsuccess without prmiss, spectag &= ~prsuccess_mask in every stage and on the incoming request as it is captured. If prmiss and prsuccess are both high, prmiss applies and prsuccess is ignored.
- res_spectag always reflects the post-clear value held in S2.
- inflight = S0.v + S1.v + S2.v.

## Timing
- Reset, synchronous, at the edge:
  - All valids cleared.
  - res_data, res_rrftag, res_spectag = 0.
  - res_valid = 0, inflight = 0.
  - req_ready = 0 while reset is high; it rises in the first cycle after reset deasserts.
- Latency: an op accepted at edge E shows res_valid=1 in the cycle after edge E+2 (3 cycles), given no stall.
- Throughput: 1 op/cycle while res_ready is held high.
- Stall: with res_ready low and all three stages full, req_ready=0. S2 holds res_data/res_rrftag stable until consumed.
- Simultaneous consume and accept when full: res_ready=1 lets all stages shift and a new op enter the same edge.
- Reset asserted mid-operation discards all in-flight ops; no result is emitted for them.

## Test plan
- Back-to-back issue:
  - Stimulus: pairs (3,4,uu,lo), (-2,5,ss,lo), (0xFFFFFFFF,0xFFFFFFFF,uu,hi), (0x80000000,2,su,hi) at cycles 1–4, res_ready=1.
  - Required: results 12, 0xFFFFFFF6, 0xFFFFFFFE, 0xFFFFFFFF in cycles 4–7 with matching rrftags. MULHSU of 0x80000000 (signed, src1) by 2 (unsigned, src2) yields 0xFFFFFFFF.
- Backpressure:
  - Stimulus: res_ready=0 and 5 requests offered.
  - Required: exactly 3 accepted, req_ready=0, inflight=3. After res_ready rises, the results drain in order with no loss or duplication.
- Mispredict squash:
  - Stimulus: ops tagged 5'b00001, 5'b00010, 5'b00010 in S2/S1/S0; prmiss with mask 5'b00010.
  - Required: only the 00001 result is produced; inflight drops to 1.
- Success clear:
  - Stimulus: op tagged 5'b00100 in flight; prsuccess with mask 5'b00100.
  - Required: res_spectag=0 on output. A later prmiss with mask 5'b00100 does not squash it.
- Concurrent prmiss/prsuccess plus accept:
  - Stimulus: both branch signals high while a request tagged to prmiss_mask is offered.
  - Required: req_ready=1, the op is dropped, and no result is produced.
- Reset mid-flight:
  - Stimulus: reset pulse with 3 ops in flight.
  - Required: the next cycle shows res_valid=0, inflight=0, res_data=0, and req_ready=1 once reset is low.
